// File: rtl/sort_pkg.sv
// Shared types and constants for the merge-sort datapath.
// Holds the merge sequencer state encoding and the tie-break policy.
package sort_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MERGE,
        DRAIN_A,
        DRAIN_B,
        FINISH
    } merge_state_e;

    // Equal heads take run A so that the merge is stable.
    localparam logic TIE_PREFERS_A = 1'b1;

endpackage : sort_pkg

// File: rtl/merge_run_sequencer.sv
// One merge step: combines two sorted runs of run_len_i elements from FIFOs A and B
// into one sorted run of 2*run_len_i elements through a one-entry output register.
module merge_run_sequencer
    import sort_pkg::*;
#(
    parameter int width_p         = 8,
    parameter int run_len_width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [run_len_width_p-1:0] run_len_i,
    input  logic [width_p-1:0]         a_data_i,
    input  logic                       a_valid_i,
    output logic                       a_ready_o,
    input  logic [width_p-1:0]         b_data_i,
    input  logic                       b_valid_i,
    output logic                       b_ready_o,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       ready_i,
    output logic                       busy_o,
    output logic                       done_o
);

    merge_state_e state_q, state_d;

    logic [run_len_width_p-1:0] cnt_a_q, cnt_a_d;
    logic [run_len_width_p-1:0] cnt_b_q, cnt_b_d;
    logic [run_len_width_p-1:0] len_q, len_d;
    logic                       valid_q, valid_d;
    logic [width_p-1:0]         data_q, data_d;
    logic                       last_q, last_d;

    logic slot_free;
    logic a_wins;
    logic pop_a;
    logic pop_b;

    assign slot_free = !valid_q || ready_i;
    assign a_wins    = TIE_PREFERS_A ? (a_data_i <= b_data_i) : (a_data_i < b_data_i);
    assign pop_a     = a_ready_o && a_valid_i;
    assign pop_b     = b_ready_o && b_valid_i;

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge value of every other flop, independent of statement order.
        if (reset_i) begin
            state_q <= IDLE;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Next state, counters and output-register load.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        len_d   = len_q;
        last_d  = last_q;
        cnt_a_d = cnt_a_q + run_len_width_p'(pop_a);
        cnt_b_d = cnt_b_q + run_len_width_p'(pop_b);

        // A pop refills the register on the same edge the old element leaves.
        if (pop_a || pop_b) begin
            valid_d = 1'b1;
            data_d  = pop_a ? a_data_i : b_data_i;
        end else begin
            valid_d = valid_q && !ready_i;
            data_d  = data_q;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d   = run_len_i;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    state_d = (run_len_i == '0) ? FINISH : MERGE;
                end
            end
            MERGE, DRAIN_A, DRAIN_B: begin
                if (pop_a || pop_b) begin
                    if (cnt_a_d == len_q && cnt_b_d == len_q) begin
                        state_d = FINISH;
                        last_d  = 1'b1;
                    end else if (cnt_a_d == len_q) begin
                        state_d = DRAIN_B;
                    end else if (cnt_b_d == len_q) begin
                        state_d = DRAIN_A;
                    end
                end
            end
            FINISH: begin
                if (done_o) begin
                    last_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pop strobes and completion pulse.
    always_comb begin
        a_ready_o = 1'b0;
        b_ready_o = 1'b0;
        done_o    = 1'b0;

        unique case (state_q)
            MERGE: begin
                // Both heads are needed to decide; a lone valid side waits.
                if (a_valid_i && b_valid_i && slot_free) begin
                    a_ready_o = a_wins;
                    b_ready_o = !a_wins;
                end
            end
            DRAIN_A: a_ready_o = a_valid_i && slot_free;
            DRAIN_B: b_ready_o = b_valid_i && slot_free;
            FINISH: begin
                // An empty merge reaches FINISH with nothing in the output register.
                done_o = last_q ? (valid_q && ready_i) : !valid_q;
            end
            default: ;
        endcase
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign busy_o  = (state_q != IDLE);

endmodule : merge_run_sequencer

// File: tb/tb_merge_run_sequencer.sv
// Directed bench for merge_run_sequencer: queue-modelled upstream FIFOs,
// recorded pops and downstream handshakes compared against hand-computed runs.
module tb_merge_run_sequencer;

    localparam int W  = 8;
    localparam int RW = 8;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic [RW-1:0] run_len_i = '0;
    logic [W-1:0]  a_data_i = '0;
    logic          a_valid_i = 1'b0;
    logic          a_ready_o;
    logic [W-1:0]  b_data_i = '0;
    logic          b_valid_i = 1'b0;
    logic          b_ready_o;
    logic          valid_o;
    logic [W-1:0]  data_o;
    logic          ready_i = 1'b0;
    logic          busy_o;
    logic          done_o;

    always #5 clk_i = ~clk_i;

    merge_run_sequencer #(.width_p(W), .run_len_width_p(RW)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .run_len_i (run_len_i),
        .a_data_i  (a_data_i),
        .a_valid_i (a_valid_i),
        .a_ready_o (a_ready_o),
        .b_data_i  (b_data_i),
        .b_valid_i (b_valid_i),
        .b_ready_o (b_ready_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] out_q[$];
    bit           src_q[$];
    int           hs_cyc[$];
    int           cyc;
    int           done_cnt, done_idx, block_pops, stable_err, onehot_err, valid_seen;
    bit           prev_hold;
    logic [W-1:0] prev_data;
    int           total, bad;

    task automatic clear_logs();
        qa.delete(); qb.delete(); out_q.delete(); src_q.delete(); hs_cyc.delete();
        done_cnt = 0; done_idx = -1; block_pops = 0; stable_err = 0;
        onehot_err = 0; valid_seen = 0; prev_hold = 1'b0;
    endtask

    // One clock: drive at negedge, sample 1ns later, apply FIFO pops at posedge.
    task automatic run_cycle(input logic rdy, input logic a_en, input logic b_en);
        logic pa, pb;
        ready_i   = rdy;
        a_valid_i = a_en && (qa.size() > 0);
        a_data_i  = (qa.size() > 0) ? qa[0] : '0;
        b_valid_i = b_en && (qb.size() > 0);
        b_data_i  = (qb.size() > 0) ? qb[0] : '0;
        #1;
        if (a_ready_o && b_ready_o) onehot_err++;
        if (!b_en && (a_ready_o || b_ready_o)) block_pops++;
        if (prev_hold && (!valid_o || data_o !== prev_data)) stable_err++;
        prev_hold = valid_o && !ready_i && !reset_i;
        prev_data = data_o;
        if (valid_o) valid_seen++;
        pa = a_ready_o && a_valid_i;
        pb = b_ready_o && b_valid_i;
        if (valid_o && ready_i) begin
            out_q.push_back(data_o);
            hs_cyc.push_back(cyc);
        end
        if (done_o) begin
            done_cnt++;
            done_idx = out_q.size();
        end
        @(posedge clk_i);
        if (pa) begin void'(qa.pop_front()); src_q.push_back(1'b1); end
        if (pb) begin void'(qb.pop_front()); src_q.push_back(1'b0); end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic start_merge(input logic [RW-1:0] len);
        start_i   = 1'b1;
        run_len_i = len;
        run_cycle(1'b1, 1'b1, 1'b1);
        start_i   = 1'b0;
    endtask

    // Ready pattern 1-0-0-1 when toggling; B masked for blk_len cycles from blk_from.
    task automatic run_until_done(input int budget, input bit toggle, input int blk_from,
                                  input int blk_len);
        int i;
        logic rdy, b_en;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            rdy  = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            b_en = !(i >= blk_from && i < blk_from + blk_len);
            run_cycle(rdy, 1'b1, b_en);
            i++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL done_timeout: got no done_o within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        clear_logs();
        qa.push_back(8'd7);
        qb.push_back(8'd9);
        reset_i = 1'b1;
        run_cycle(1'b1, 1'b1, 1'b1);
        run_cycle(1'b1, 1'b1, 1'b1);
        reset_i = 1'b0;
        total++;
        if ({valid_o, busy_o, done_o, a_ready_o, b_ready_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got v=%b busy=%b done=%b ar=%b br=%b required all 0",
                     valid_o, busy_o, done_o, a_ready_o, b_ready_o);
        end
        total++;
        if (data_o !== '0) begin
            bad++;
            $display("FAIL reset_data: got %0d required 0", data_o);
        end
    endtask

    task automatic test_basic_merge();
        logic [W-1:0] exp_d [8];
        exp_d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        clear_logs();
        qa = '{8'd1, 8'd3, 8'd5, 8'd7};
        qb = '{8'd2, 8'd4, 8'd6, 8'd8};
        start_merge(8'd4);
        run_until_done(60, 1'b0, 0, 0);
        total++;
        if (out_q.size() != 8) begin
            bad++;
            $display("FAIL basic_count: got %0d required 8", out_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (out_q[i] !== exp_d[i]) begin
                    bad++;
                    $display("FAIL basic_data[%0d]: got %0d required %0d", i, out_q[i], exp_d[i]);
                end
            end
            total++;
            if (hs_cyc[7] - hs_cyc[0] != 7) begin
                bad++;
                $display("FAIL basic_throughput: got span %0d required 7", hs_cyc[7] - hs_cyc[0]);
            end
        end
        total++;
        if (done_cnt != 1 || done_idx != 8) begin
            bad++;
            $display("FAIL basic_done: got count=%0d at_elem=%0d required 1 at 8", done_cnt, done_idx);
        end
        total++;
        if (busy_o !== 1'b0 || onehot_err != 0) begin
            bad++;
            $display("FAIL basic_idle: got busy=%b onehot_err=%0d required 0/0", busy_o, onehot_err);
        end
    endtask

    task automatic test_stable_ties();
        logic [W-1:0] exp_d [6];
        bit           exp_s [6];
        exp_d = '{8'd5, 8'd5, 8'd5, 8'd6, 8'd6, 8'd9};
        exp_s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_logs();
        qa = '{8'd5, 8'd5, 8'd9};
        qb = '{8'd5, 8'd6, 8'd6};
        start_merge(8'd3);
        run_until_done(60, 1'b0, 0, 0);
        total++;
        if (out_q.size() != 6 || src_q.size() != 6) begin
            bad++;
            $display("FAIL ties_count: got out=%0d pops=%0d required 6/6", out_q.size(), src_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (out_q[i] !== exp_d[i] || src_q[i] !== exp_s[i]) begin
                    bad++;
                    $display("FAIL ties_elem[%0d]: got %0d from_a=%b required %0d from_a=%b",
                             i, out_q[i], src_q[i], exp_d[i], exp_s[i]);
                end
            end
        end
    endtask

    task automatic test_drain();
        logic [W-1:0] exp_d [8];
        exp_d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd11, 8'd12, 8'd13};
        clear_logs();
        // Trailing sentinels reveal any pop beyond the run length.
        qa = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
        qb = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd0};
        start_merge(8'd4);
        run_until_done(60, 1'b0, 0, 0);
        total++;
        if (out_q.size() != 8 || src_q.size() != 8) begin
            bad++;
            $display("FAIL drain_count: got out=%0d pops=%0d required 8/8", out_q.size(), src_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (out_q[i] !== exp_d[i] || src_q[i] !== (i < 4)) begin
                    bad++;
                    $display("FAIL drain_elem[%0d]: got %0d from_a=%b required %0d from_a=%b",
                             i, out_q[i], src_q[i], exp_d[i], (i < 4));
                end
            end
        end
        total++;
        if (qa.size() != 1 || qb.size() != 1) begin
            bad++;
            $display("FAIL drain_overread: got left a=%0d b=%0d required 1/1", qa.size(), qb.size());
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_d [8];
        exp_d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        clear_logs();
        qa = '{8'd1, 8'd3, 8'd5, 8'd7};
        qb = '{8'd2, 8'd4, 8'd6, 8'd8};
        start_merge(8'd4);
        run_until_done(100, 1'b1, 1, 3);
        total++;
        if (out_q.size() != 8) begin
            bad++;
            $display("FAIL bp_count: got %0d required 8", out_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (out_q[i] !== exp_d[i]) begin
                    bad++;
                    $display("FAIL bp_data[%0d]: got %0d required %0d", i, out_q[i], exp_d[i]);
                end
            end
        end
        total++;
        if (stable_err != 0 || block_pops != 0 || onehot_err != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL bp_protocol: got stable_err=%0d block_pops=%0d onehot=%0d done=%0d required 0/0/0/1",
                     stable_err, block_pops, onehot_err, done_cnt);
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        qa.push_back(8'd3);
        qb.push_back(8'd4);
        start_merge(8'd0);
        run_cycle(1'b1, 1'b1, 1'b1);
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL zero_done_timing: got %0d pulses one cycle after start required 1", done_cnt);
        end
        run_cycle(1'b1, 1'b1, 1'b1);
        run_cycle(1'b1, 1'b1, 1'b1);
        total++;
        if (done_cnt != 1 || valid_seen != 0 || qa.size() != 1 || qb.size() != 1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL zero_len: got done=%0d valid_cycles=%0d left a=%0d b=%0d busy=%b required 1/0/1/1/0",
                     done_cnt, valid_seen, qa.size(), qb.size(), busy_o);
        end
    endtask

    task automatic test_reset_mid_merge();
        logic [W-1:0] exp_d [8];
        bit           exp_s [8];
        int           i;
        exp_d = '{8'd2, 8'd3, 8'd4, 8'd9, 8'd20, 8'd21, 8'd30, 8'd31};
        exp_s = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        clear_logs();
        qa = '{8'd1, 8'd3, 8'd5, 8'd7};
        qb = '{8'd2, 8'd4, 8'd6, 8'd8};
        start_merge(8'd4);
        i = 0;
        while (out_q.size() < 3 && i < 30) begin
            run_cycle(1'b1, 1'b1, 1'b1);
            i++;
        end
        reset_i = 1'b1;
        run_cycle(1'b1, 1'b1, 1'b1);
        reset_i = 1'b0;
        total++;
        if ({valid_o, busy_o, a_ready_o, b_ready_o} !== 4'b0 || data_o !== '0) begin
            bad++;
            $display("FAIL midreset: got v=%b busy=%b ar=%b br=%b data=%0d required all 0",
                     valid_o, busy_o, a_ready_o, b_ready_o, data_o);
        end

        clear_logs();
        qa = '{8'd2, 8'd9, 8'd20, 8'd21};
        qb = '{8'd3, 8'd4, 8'd30, 8'd31};
        start_merge(8'd4);
        // A start pulse with a different length mid-merge must change nothing.
        for (int k = 0; k < 3; k++) begin
            start_i   = (k == 1);
            run_len_i = 8'd1;
            run_cycle(1'b1, 1'b1, 1'b1);
        end
        start_i = 1'b0;
        run_until_done(60, 1'b0, 0, 0);
        total++;
        if (out_q.size() != 8 || src_q.size() != 8) begin
            bad++;
            $display("FAIL restart_count: got out=%0d pops=%0d required 8/8", out_q.size(), src_q.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                total++;
                if (out_q[j] !== exp_d[j] || src_q[j] !== exp_s[j]) begin
                    bad++;
                    $display("FAIL restart_elem[%0d]: got %0d from_a=%b required %0d from_a=%b",
                             j, out_q[j], src_q[j], exp_d[j], exp_s[j]);
                end
            end
        end
        total++;
        if (done_cnt != 1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL restart_done: got done=%0d busy=%b required 1/0", done_cnt, busy_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        @(negedge clk_i);
        test_reset();
        test_basic_merge();
        test_stable_ties();
        test_drain();
        test_backpressure();
        test_zero_len();
        test_reset_mid_merge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_merge_run_sequencer

// File: doc/merge_run_sequencer.md
Name: merge_run_sequencer

Overview:
Sequences one merge step of the FPGA merge sort. Consumes two sorted runs, each of length run_len_i, from two upstream fifo_1r1w outputs (A and B). Emits a single sorted run of 2*run_len_i elements through a one-entry registered output stage, normally feeding a downstream fifo_1r1w. Controls both FIFO read sides through ready/valid and signals completion so the top-level pass controller can start the next merge.

Parameters:
width_p, 8, element width; elements compare as unsigned
run_len_width_p, 8, width of run_len_i and of the per-side consumed counters

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous, active-high reset
start_i  input  1  begin a merge; sampled only in IDLE
run_len_i  input  run_len_width_p  elements per input run; latched on accepted start
a_data_i  input  width_p  head of run A
a_valid_i  input  1  run A head valid
a_ready_o  output  1  pop run A
b_data_i  input  width_p  head of run B
b_valid_i  input  1  run B head valid
b_ready_o  output  1  pop run B
valid_o  output  1  output register holds an element
data_o  output  width_p  output element
ready_i  input  1  downstream accepts data_o
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle pulse when the final merged element is accepted downstream

Behaviour:
- Reset: state=IDLE, cnt_a=cnt_b=0, len_r=0, valid_o=0, data_o=0, last_r=0, done_o=0, a_ready_o=b_ready_o=0. Reset mid-merge discards all in-flight state, including the output register contents.
- slot_free = !valid_o | ready_i. A pop writes the selected head into the output register on the same edge. Latency: pop to valid_o is 1 cycle.
- Pops are one-hot: at most one of a_ready_o/b_ready_o is high per cycle. Ready outputs may depend combinationally on a_valid_i, b_valid_i, the data inputs and ready_i. valid_o never depends on ready_i.
- IDLE:
  - Both readies are 0.
  - start_i=1 latches len_r=run_len_i and clears the counters.
  - If run_len_i==0, go to FINISH. Otherwise go to MERGE.
- MERGE:
  - Pops only when a_valid_i & b_valid_i & slot_free. A single valid side is never popped.
  - Selects A if a_data_i <= b_data_i, else B. Ties go to A, so the merge is stable.
  - The popped side's counter increments.
  - A pop that makes cnt_a==len_r moves to DRAIN_B. A pop that makes cnt_b==len_r moves to DRAIN_A.
- DRAIN_A: pops A when a_valid_i & slot_free. b_ready_o=0. B is never over-read.
- DRAIN_B: symmetric to DRAIN_A.
- The pop that makes both counters equal len_r sets last_r alongside the data and moves to FINISH.
- FINISH:
  - No pops.
  - When valid_o & ready_i & last_r: done_o=1 for that cycle, last_r clears, next state IDLE.
  - run_len 0 case: FINISH is entered with valid_o=0. done_o pulses on the next cycle, then next state IDLE.
- Counters are run_len_width_p bits wide. The maximum is 2^run_len_width_p-1, so they never wrap within a run.
- start_i outside IDLE is ignored. start_i in the same cycle as done_o is also ignored, because the state is still FINISH.
- Throughput: one element per cycle with ready_i held at 1 and both heads valid.
- No assumption about upstream data: ordering is guaranteed only if both input runs are sorted.

Decomposition:
- Shared package sort_pkg holds:
  - enum merge_state_e {IDLE, MERGE, DRAIN_A, DRAIN_B, FINISH}
  - a tie-break constant TIE_PREFERS_A=1'b1
- No sub-module. The select/compare logic is a few lines inline. The FIFOs are instantiated by the parent, not inside this block.

Test Plan:
- len=4, A={1,3,5,7}, B={2,4,6,8}, ready_i=1 -> data_o 1..8 on consecutive cycles; done_o high on the handshake of 8, then busy_o=0.
- len=3, A={5,5,9}, B={5,6,6}, with source-tagged data -> order A5,A5,B5,B6,B6,A9; ties always take A.
- len=4, A={1,2,3,4}, B={10,11,12,13} -> A fully drains first, then DRAIN_B emits 10..13. b_ready_o is never high while A is pending, and there is no pop beyond 4 per side.
- Same as the first case but ready_i toggles 1-0-0-1 and b_valid_i drops for 3 cycles -> no loss or duplication, data_o stable while valid_o&!ready_i, no pops while b_valid_i=0 in MERGE.
- start_i with run_len_i=0 -> no pops, valid_o stays 0, done_o pulses exactly once, back to IDLE.
- Reset asserted after 3 outputs of len=4 -> next cycle valid_o=0, busy_o=0, readies 0. A new start with fresh runs merges correctly. A start_i pulse issued mid-merge (without reset) is ignored.
